// File: rtl/uart_transmitter.sv
// uart_transmitter: 8N1 LSB-first serial transmitter with a ready/valid byte input.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frame).
module uart_transmitter #(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       data_in_valid,
  output logic       data_in_ready,
  output logic       serial_out,
  output logic       tx_busy
);

  localparam int T  = CLOCK_FREQ / BAUD_RATE;
  localparam int CW = (T > 1) ? $clog2(T) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(T - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
`ifdef UART_TX_PARITY_EN
  logic            par;
`endif

  logic bit_end;
  logic take;

  assign bit_end = (cnt == CNT_MAX);
  assign take    = data_in_valid && data_in_ready;
  assign tx_busy = !data_in_ready;

  // Frame sequencer: every output is registered and updated on bit edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shift         <= '0;
      serial_out    <= 1'b1;
      data_in_ready <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par           <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (take) begin
            shift         <= data_in;
`ifdef UART_TX_PARITY_EN
            par           <= ^data_in;
`endif
            state         <= START;
            cnt           <= '0;
            bit_idx       <= '0;
            serial_out    <= 1'b0;
            data_in_ready <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            cnt        <= '0;
            state      <= DATA;
            serial_out <= shift[0];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt     <= '0;
            shift   <= shift >> 1;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state      <= PARITY;
              serial_out <= par;
`else
              state      <= STOP;
              serial_out <= 1'b1;
`endif
            end else begin
              serial_out <= shift[1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            cnt        <= '0;
            state      <= STOP;
            serial_out <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            cnt           <= '0;
            state         <= IDLE;
            serial_out    <= 1'b1;
            data_in_ready <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state         <= IDLE;
          cnt           <= '0;
          serial_out    <= 1'b1;
          data_in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: table-driven frames plus hand-written corner sequences,
// with a queue of expected bytes popped as each frame is decoded off the line.
module tb_uart_transmitter;

`ifdef UART_TX_PARITY_EN
  localparam int FL = 11;
`else
  localparam int FL = 10;
`endif
  localparam int T = 10;

  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_in;
  logic       data_in_valid;
  logic       data_in_ready;
  logic       serial_out;
  logic       tx_busy;

  int   cyc = 0;
  int   e0 = 0;
  int   nvec = 0;
  int   nerr = 0;
  vec_t q[$];
  vec_t tbl[7];

  uart_transmitter #(
    .CLOCK_FREQ(100_000_000),
    .BAUD_RATE (10_000_000)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready),
    .serial_out   (serial_out),
    .tx_busy      (tx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic got, input logic want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %b want %b", name, got, want);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_check(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk({name, "_line"}, serial_out, 1'b1);
      chk({name, "_ready"}, data_in_ready, 1'b1);
    end
  endtask

  task automatic send(input vec_t v, input bit hold);
    int n;
    n = 0;
    while (!data_in_ready && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("ready_before_send", data_in_ready, 1'b1);
    @(negedge clk);
    data_in       = v.data;
    data_in_valid = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    if (!hold) data_in_valid = 1'b0;
    q.push_back(v);
    chk("start_at_e0", serial_out, 1'b0);
    chk("busy_at_e0", tx_busy, 1'b1);
  endtask

  task automatic check_frame(input int base);
    vec_t          v;
    logic [FL-1:0] fb;
    if (q.size() == 0) begin
      nvec++;
      nerr++;
      $display("FAIL scoreboard: got empty queue want byte");
      return;
    end
    v = q.pop_front();
`ifdef UART_TX_PARITY_EN
    fb = {1'b1, v.par, v.data, 1'b0};
`else
    fb = {1'b1, v.data, 1'b0};
`endif
    for (int i = 0; i < FL; i++) begin
      wait_cyc(base + 5 + T * i);
      chk($sformatf("byte%02h_bit%0d", v.data, i), serial_out, fb[i]);
    end
    wait_cyc(base + FL * T - 1);
    chk($sformatf("byte%02h_ready_early", v.data), data_in_ready, 1'b0);
    wait_cyc(base + FL * T);
    chk($sformatf("byte%02h_ready", v.data), data_in_ready, 1'b1);
    chk($sformatf("byte%02h_busy", v.data), tx_busy, 1'b0);
  endtask

  initial begin
    int   base;
    vec_t v;

    tbl[0] = '{8'h45, 1'b1};
    tbl[1] = '{8'h00, 1'b0};
    tbl[2] = '{8'hFF, 1'b0};
    tbl[3] = '{8'h80, 1'b1};
    tbl[4] = '{8'h01, 1'b1};
    tbl[5] = '{8'h07, 1'b1};
    tbl[6] = '{8'hC3, 1'b0};

    rst_n         = 1'b0;
    data_in_valid = 1'b0;
    data_in       = 8'h00;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      data_in_valid = ~data_in_valid;
      data_in       = 8'($urandom);
      #1;
      chk("rst_line", serial_out, 1'b1);
      chk("rst_ready", data_in_ready, 1'b1);
      chk("rst_busy", tx_busy, 1'b0);
    end
    @(negedge clk);
    rst_n         = 1'b1;
    data_in_valid = 1'b0;
    @(posedge clk);
    #1;
    idle_check("post_rst", 20);

    for (int i = 0; i < 7; i++) begin
      send(tbl[i], 1'b0);
      check_frame(e0);
    end

    send('{8'h67, 1'b1}, 1'b1);
    data_in = 8'hA5;
    base    = e0;
    fork
      check_frame(base);
      begin
        wait_cyc(base + FL * T);
        chk("b2b_gap_line", serial_out, 1'b1);
        chk("b2b_gap_ready", data_in_ready, 1'b1);
        wait_cyc(base + FL * T + 1);
        chk("b2b_second_start", serial_out, 1'b0);
        chk("b2b_second_busy", tx_busy, 1'b1);
        data_in_valid = 1'b0;
        q.push_back('{8'hA5, 1'b0});
      end
    join
    check_frame(base + FL * T + 1);

    send('{8'h5A, 1'b0}, 1'b0);
    base = e0;
    fork
      check_frame(base);
      begin
        wait_cyc(base + 29);
        @(negedge clk);
        data_in       = 8'hFF;
        data_in_valid = 1'b1;
        @(posedge clk);
        #1;
        data_in_valid = 1'b0;
      end
    join
    idle_check("no_extra_frame", 30);

    send('{8'h3C, 1'b0}, 1'b0);
    base = e0;
    wait_cyc(base + 43);
    rst_n = 1'b0;
    #1;
    chk("midrst_line", serial_out, 1'b1);
    chk("midrst_ready", data_in_ready, 1'b1);
    chk("midrst_busy", tx_busy, 1'b0);
    v = q.pop_front();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle_check("midrst_release", 20);
    send('{8'h0F, 1'b0}, 1'b0);
    check_frame(e0);

    chk("queue_empty", q.size() == 0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
